pdu_rb_reader: RTL and testbench
================================

// Module: pdu_rb_reader
// PURPOSE
// Consumer end of the PDU ring buffer that pdu_gen fills.
// - Tracks flits the writer has committed, from the writer's update pulses.
// - Reads each PDU (one header flit + N payload flits) out of ring memory and
//   replays the payload as a sop/eop/empty packet stream.
// - Returns freed space to the writer with a free pulse.
// - Sits on the host/loopback side of the DMA path; used for checking and CPU-bypass replay.
// PARAMETERS
// PDU_AWIDTH      12  ring address width; ring depth RB_DEPTH = 2**PDU_AWIDTH flits
// RD_LAT          2   ring memory read latency in cycles (rb_rd_en -> rb_rd_data valid)
// MAX_PDU_FLITS   32  largest legal payload flit count N
// OUT_FIFO_DEPTH  8   output buffer depth in flits; must be >= RD_LAT+2
// PORTS
// clk                 in   1             clock
// rst                 in   1             synchronous reset, active-high
// rb_wr_update_valid  in   1             writer committed rb_wr_update_size more flits
// rb_wr_update_size   in   PDU_AWIDTH    flits committed by this update
// rb_rd_en            out  1             ring memory read strobe
// rb_rd_addr          out  PDU_AWIDTH    ring memory read address
// rb_rd_data          in   512           read data, valid RD_LAT cycles after rb_rd_en
// rb_free_valid       out  1             one-cycle pulse: rb_free_size flits released to writer
// rb_free_size        out  PDU_AWIDTH    flits released (N+1, or 1 on a bad header)
// out_data            out  512           payload flit
// out_sop             out  1             first payload flit of a PDU
// out_eop             out  1             last payload flit of a PDU
// out_empty           out  6             empty bytes on the eop flit; 0 otherwise
// out_valid           out  1             output flit valid
// out_ready           in   1             downstream accepts when out_valid&out_ready
// rb_avail            out  PDU_AWIDTH+1  committed, unconsumed flits
// stat_pdu_cnt        out  32            PDUs fully emitted (wraps at 2**32)
// err_hdr             out  1             sticky: header with N==0 or N>MAX_PDU_FLITS
// err_overflow        out  1             sticky: rb_avail would exceed RB_DEPTH
// BEHAVIOUR
// Reset (rst=1 at a clock edge): every output 0, tail pointer 0, rb_avail 0, FSM IDLE.
//   Output FIFO and in-flight reads are discarded, even mid-PDU.
// Header flit layout: [15:0] = N, payload flit count; [21:16] = eop empty; other bits ignored.
// Addresses: rd_ptr = tail + i, wrapping modulo RB_DEPTH by natural overflow.
//   tail advances by rb_free_size in the cycle rb_free_valid fires.
// rb_avail <= rb_avail + (upd_valid ? upd_size : 0) - (free_valid ? free_size : 0).
//   Update and free in the same cycle are both applied.
//   If the result exceeds RB_DEPTH: set err_overflow and saturate at RB_DEPTH.
// Credit rule: a payload read issues only while fifo_count + inflight < OUT_FIFO_DEPTH.
//   This guarantees no data loss under any out_ready pattern.
// At most one read per cycle; no read is ever issued to a flit outside rb_avail.
// FSM:
//   IDLE      rb_avail>=1 and out FIFO empty of header work -> pulse rb_rd_en at tail;
//             go HDR_WAIT.
//   HDR_WAIT  after RD_LAT cycles, latch N and empty.
//             N==0 or N>MAX_PDU_FLITS: set err_hdr, free 1 flit, go IDLE.
//             Otherwise go BODY_WAIT.
//   BODY_WAIT wait for rb_avail >= N+1, then go BODY.
//   BODY      issue reads at tail+1 .. tail+N, honouring credits.
//             Each returned flit is written to the out FIFO with sop on i==1,
//             eop and empty on i==N. After the last issued read, go DRAIN.
//   DRAIN     once the last payload flit is captured in the FIFO (not yet emitted):
//             pulse rb_free_valid with size N+1, advance tail, go IDLE.
// stat_pdu_cnt increments on the eop handshake at the output.
// Output FIFO is show-ahead. out_valid means not empty. Pop on out_valid&out_ready.
// Latency, empty ring with full credits: header update -> first out_valid = 2*RD_LAT+2 cycles.
// Next header read may issue the cycle after rb_free_valid; back-to-back PDUs need no idle flit.
// TESTING
// 1. Reset, update size 4, ring[0]={N=3,empty=10}, ring[1..3]=P1..P3 ->
//    out P1 sop, P2, P3 eop empty=10; rb_free_valid size 4; rb_avail 0; stat_pdu_cnt 1.
// 2. Wrap: PDUAWIDTH=4; tail=14, N=3 occupying flits 14,15,0,1 ->
//    reads at addresses 14,15,0,1 in order; tail ends at 2.
// 3. Backpressure: out_ready=0 for 20 cycles during N=16 PDU ->
//    no more than OUT_FIFO_DEPTH flits buffered, no loss, correct order after release.
// 4. Bad header: N=0 -> err_hdr=1, rb_free_size=1, no output flit;
//    next valid PDU still emitted correctly.
// 5. Partial commit: header with N=5 but only 3 flits committed ->
//    stays in BODY_WAIT with no payload reads; update of 3 -> PDU completes.
// 6. Same-cycle update 5 and free 4 with rb_avail=4 -> rb_avail=5.
//    Assert rst mid-BODY -> all outputs 0 the next cycle, no further rb_rd_en.

Source files
------------

// File: rtl/pdu_rb_reader.sv
// Consumer side of the PDU ring buffer: tracks committed flits, reads each PDU
// (header + N payload flits) and replays the payload as a sop/eop packet stream.
module pdu_rb_reader #(
    parameter int PDU_AWIDTH     = 12,
    parameter int RD_LAT         = 2,
    parameter int MAX_PDU_FLITS  = 32,
    parameter int OUT_FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rb_wr_update_valid,
    input  logic [PDU_AWIDTH-1:0] rb_wr_update_size,
    output logic                  rb_rd_en,
    output logic [PDU_AWIDTH-1:0] rb_rd_addr,
    input  logic [511:0]          rb_rd_data,
    output logic                  rb_free_valid,
    output logic [PDU_AWIDTH-1:0] rb_free_size,
    output logic [511:0]          out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [5:0]            out_empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PDU_AWIDTH:0]   rb_avail,
    output logic [31:0]           stat_pdu_cnt,
    output logic                  err_hdr,
    output logic                  err_overflow
);
    // state     | meaning
    // S_IDLE    | waiting for a committed flit; reads the header at tail
    // S_HDR_WAIT| header read in flight; validates N on return
    // S_BODY_WAIT| waiting until the whole PDU (N+1 flits) is committed
    // S_BODY    | issuing payload reads tail+1..tail+N under FIFO credits
    // S_DRAIN   | last payload read in flight; frees N+1 flits once captured

    localparam int FAW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(OUT_FIFO_DEPTH + 1);
    localparam int AVW = PDU_AWIDTH + 2;
    localparam int L   = RD_LAT - 1;
    localparam logic [AVW-1:0] RB_DEPTH_V = AVW'(2 ** PDU_AWIDTH);
    localparam logic [15:0]    MAX_N      = 16'(MAX_PDU_FLITS);
    localparam logic [CW:0]    CREDITS    = (CW + 1)'(OUT_FIFO_DEPTH);
    localparam logic [FAW-1:0] LAST_SLOT  = FAW'(OUT_FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_WAIT,
        S_BODY_WAIT,
        S_BODY,
        S_DRAIN
    } state_t;

    state_t state, state_nx;

    logic [PDU_AWIDTH-1:0] tail;
    logic [15:0]           hdr_n;
    logic [5:0]            hdr_empty;
    logic [15:0]           rd_idx;
    logic [CW-1:0]         inflight;

    logic [RD_LAT-1:0] pipe_vld, pipe_hdr, pipe_sop, pipe_eop;

    logic [511:0]   fifo_data [OUT_FIFO_DEPTH];
    logic [7:0]     fifo_meta [OUT_FIFO_DEPTH];
    logic [FAW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]  fifo_count;

    logic rd_is_hdr, latch_hdr, set_err_hdr;
    logic hdr_ret, pay_ret, ret_bad, credit_ok, avail_ok, push, pop;
    logic [AVW-1:0] avail_sum;

    assign hdr_ret   = pipe_vld[L] & pipe_hdr[L];
    assign pay_ret   = pipe_vld[L] & ~pipe_hdr[L];
    assign ret_bad   = (rb_rd_data[15:0] == 16'd0) || (rb_rd_data[15:0] > MAX_N);
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < CREDITS;
    assign avail_ok  = 32'(rb_avail) >= (32'(hdr_n) + 32'd1);
    assign push      = pay_ret;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nx      = state;
        rb_rd_en      = 1'b0;
        rb_rd_addr    = '0;
        rd_is_hdr     = 1'b0;
        rb_free_valid = 1'b0;
        rb_free_size  = '0;
        latch_hdr     = 1'b0;
        set_err_hdr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rb_avail != '0) begin
                    rb_rd_en   = 1'b1;
                    rb_rd_addr = tail;
                    rd_is_hdr  = 1'b1;
                    state_nx   = S_HDR_WAIT;
                end
            end
            S_HDR_WAIT: begin
                if (hdr_ret) begin
                    latch_hdr = 1'b1;
                    if (ret_bad) begin
                        set_err_hdr   = 1'b1;
                        rb_free_valid = 1'b1;
                        rb_free_size  = PDU_AWIDTH'(1);
                        state_nx      = S_IDLE;
                    end else begin
                        state_nx = S_BODY_WAIT;
                    end
                end
            end
            // The first payload read leaves in the same cycle the PDU is seen complete.
            S_BODY_WAIT, S_BODY: begin
                if (state == S_BODY || avail_ok) begin
                    state_nx = S_BODY;
                    if (credit_ok) begin
                        rb_rd_en   = 1'b1;
                        rb_rd_addr = tail + PDU_AWIDTH'(rd_idx);
                        if (rd_idx == hdr_n) state_nx = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (inflight == '0) begin
                    rb_free_valid = 1'b1;
                    rb_free_size  = PDU_AWIDTH'(hdr_n + 16'd1);
                    state_nx      = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        avail_sum = {1'b0, rb_avail};
        if (rb_wr_update_valid) avail_sum = avail_sum + AVW'(rb_wr_update_size);
        if (rb_free_valid)      avail_sum = avail_sum - AVW'(rb_free_size);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            tail         <= '0;
            rb_avail     <= '0;
            hdr_n        <= '0;
            hdr_empty    <= '0;
            rd_idx       <= '0;
            inflight     <= '0;
            pipe_vld     <= '0;
            pipe_hdr     <= '0;
            pipe_sop     <= '0;
            pipe_eop     <= '0;
            err_hdr      <= 1'b0;
            err_overflow <= 1'b0;
            stat_pdu_cnt <= '0;
        end else begin
            state <= state_nx;
            if (rb_free_valid) tail <= tail + rb_free_size;
            if (avail_sum > RB_DEPTH_V) begin
                rb_avail     <= RB_DEPTH_V[PDU_AWIDTH:0];
                err_overflow <= 1'b1;
            end else begin
                rb_avail <= avail_sum[PDU_AWIDTH:0];
            end
            if (set_err_hdr) err_hdr <= 1'b1;
            if (latch_hdr) begin
                hdr_n     <= rb_rd_data[15:0];
                hdr_empty <= rb_rd_data[21:16];
                rd_idx    <= 16'd1;
            end else if (rb_rd_en && !rd_is_hdr) begin
                rd_idx <= rd_idx + 16'd1;
            end
            inflight    <= inflight + CW'(rb_rd_en) - CW'(pipe_vld[L]);
            pipe_vld[0] <= rb_rd_en;
            pipe_hdr[0] <= rd_is_hdr;
            pipe_sop[0] <= rb_rd_en && !rd_is_hdr && (rd_idx == 16'd1);
            pipe_eop[0] <= rb_rd_en && !rd_is_hdr && (rd_idx == hdr_n);
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_hdr[i] <= pipe_hdr[i-1];
                pipe_sop[i] <= pipe_sop[i-1];
                pipe_eop[i] <= pipe_eop[i-1];
            end
            if (pop && out_eop) stat_pdu_cnt <= stat_pdu_cnt + 32'd1;
        end
    end

    // Output buffer storage is not reset; the gated read side hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= rb_rd_data;
            fifo_meta[wr_ptr] <= {pipe_sop[L], pipe_eop[L], pipe_eop[L] ? hdr_empty : 6'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + FAW'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + FAW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        out_valid = (fifo_count != '0);
        out_data  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_empty = '0;
        if (out_valid) begin
            out_data  = fifo_data[rd_ptr];
            out_sop   = fifo_meta[rd_ptr][7];
            out_eop   = fifo_meta[rd_ptr][6];
            out_empty = fifo_meta[rd_ptr][5:0];
        end
    end

endmodule

// File: tb/tb_pdu_rb_reader.sv
// Bench for pdu_rb_reader: the bench acts as ring writer and ring memory, and
// predicts read addresses, output flits and free sizes from the PDUs it writes.
module tb_pdu_rb_reader;
    localparam int AW     = 6;
    localparam int DEPTH  = 64;
    localparam int FIFO_D = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rb_wr_update_valid;
    logic [AW-1:0] rb_wr_update_size;
    logic          rb_rd_en;
    logic [AW-1:0] rb_rd_addr;
    logic [511:0]  rb_rd_data;
    logic          rb_free_valid;
    logic [AW-1:0] rb_free_size;
    logic [511:0]  out_data;
    logic          out_sop, out_eop, out_valid, out_ready;
    logic [5:0]    out_empty;
    logic [AW:0]   rb_avail;
    logic [31:0]   stat_pdu_cnt;
    logic          err_hdr, err_overflow;

    pdu_rb_reader #(.PDU_AWIDTH(AW), .RD_LAT(2), .MAX_PDU_FLITS(32), .OUT_FIFO_DEPTH(FIFO_D)) dut (
        .clk(clk), .rst(rst),
        .rb_wr_update_valid(rb_wr_update_valid), .rb_wr_update_size(rb_wr_update_size),
        .rb_rd_en(rb_rd_en), .rb_rd_addr(rb_rd_addr), .rb_rd_data(rb_rd_data),
        .rb_free_valid(rb_free_valid), .rb_free_size(rb_free_size),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
        .out_valid(out_valid), .out_ready(out_ready),
        .rb_avail(rb_avail), .stat_pdu_cnt(stat_pdu_cnt),
        .err_hdr(err_hdr), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
    } flit_t;
    typedef struct packed {
        logic          hdr;
        logic [AW-1:0] addr;
    } rd_t;

    flit_t exp_out[$];
    rd_t   exp_rd[$];
    int    exp_free[$];

    logic [511:0]  ring [DEPTH];
    logic [511:0]  mem_s1;
    logic [AW-1:0] head = '0;
    int checks = 0, errors = 0;
    int n_pay_rd = 0, n_pop = 0, n_pdus = 0, outstanding = 0, uncommitted = 0;
    bit mon_on = 0, rand_ready = 0;
    rd_t   mon_rd;
    flit_t mon_f;
    int    mon_sz;

    // Ring memory with two cycles of read latency.
    always @(posedge clk) begin
        mem_s1     <= ring[rb_rd_addr];
        rb_rd_data <= mem_s1;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (rb_rd_en) begin
                checks++;
                assert (exp_rd.size() > 0) else begin
                    errors++;
                    $error("FAIL rd_unexpected: observed read at %0h expected no read", rb_rd_addr);
                end
                if (exp_rd.size() > 0) begin
                    mon_rd = exp_rd.pop_front();
                    chk("rd_addr", rb_rd_addr, mon_rd.addr);
                    if (!mon_rd.hdr) begin
                        n_pay_rd++;
                        chk("fifo_bound", (n_pay_rd - n_pop) <= FIFO_D, 1'b1);
                    end
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_out.size() > 0) else begin
                    errors++;
                    $error("FAIL out_unexpected: observed flit %0h expected none", out_data);
                end
                if (exp_out.size() > 0) begin
                    mon_f = exp_out.pop_front();
                    chk("out_data", out_data, mon_f.data);
                    chk("out_sop", out_sop, mon_f.sop);
                    chk("out_eop", out_eop, mon_f.eop);
                    chk("out_empty", out_empty, mon_f.empty);
                    n_pop++;
                    if (mon_f.eop) n_pdus++;
                end
            end
            if (rb_free_valid) begin
                checks++;
                assert (exp_free.size() > 0) else begin
                    errors++;
                    $error("FAIL free_unexpected: observed size %0d expected no free", rb_free_size);
                end
                if (exp_free.size() > 0) begin
                    mon_sz = exp_free.pop_front();
                    chk("free_size", rb_free_size, mon_sz);
                    outstanding -= mon_sz;
                end
            end
        end
    end

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Writes one PDU into the ring at head and records what the reader must do with it.
    task automatic write_pdu(input int n, input logic [5:0] emp);
        logic [511:0]  w;
        logic [AW-1:0] a;
        w         = rand512();
        w[15:0]   = 16'(n);
        w[21:16]  = emp;
        ring[head] = w;
        exp_rd.push_back(rd_t'{hdr: 1'b1, addr: head});
        if (n == 0 || n > 32) begin
            exp_free.push_back(1);
            outstanding += 1;
            uncommitted += 1;
            head = head + AW'(1);
        end else begin
            for (int i = 1; i <= n; i++) begin
                a = head + AW'(i);
                w = rand512();
                ring[a] = w;
                exp_rd.push_back(rd_t'{hdr: 1'b0, addr: a});
                exp_out.push_back(flit_t'{data: w, sop: (i == 1), eop: (i == n),
                                          empty: (i == n) ? emp : 6'd0});
            end
            exp_free.push_back(n + 1);
            outstanding += n + 1;
            uncommitted += n + 1;
            head = head + AW'(n + 1);
        end
    endtask

    task automatic commit(input int sz);
        rb_wr_update_valid = 1'b1;
        rb_wr_update_size  = AW'(sz);
        uncommitted -= sz;
        step();
        rb_wr_update_valid = 1'b0;
        rb_wr_update_size  = '0;
    endtask

    task automatic wait_drain(input string tag);
        int budget = 3000;
        while ((exp_out.size() + exp_rd.size() + exp_free.size()) != 0 && budget > 0) begin
            step();
            budget--;
        end
        repeat (2) step();
        chk(tag, exp_out.size() + exp_rd.size() + exp_free.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"}, rb_rd_en, 1'b0);
        chk({tag, "_rd_addr"}, rb_rd_addr, '0);
        chk({tag, "_free_valid"}, rb_free_valid, 1'b0);
        chk({tag, "_free_size"}, rb_free_size, '0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_out_flags"}, {out_sop, out_eop, out_empty}, '0);
        chk({tag, "_avail"}, rb_avail, '0);
        chk({tag, "_stat"}, stat_pdu_cnt, '0);
        chk({tag, "_errs"}, {err_hdr, err_overflow}, '0);
    endtask

    initial begin
        int lat, base_rd, base_pop, flits, n, k, b, cnt;
        rst = 1'b1;
        rb_wr_update_valid = 1'b0;
        rb_wr_update_size  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ring[i] = '0;
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;
        out_ready = 1'b1;
        mon_on = 1;
        step();

        // Single PDU on an empty ring, including first-flit latency.
        write_pdu(3, 6'd10);
        commit(4);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!out_valid && lat < 50);
        chk("latency", lat, 6);
        wait_drain("t1_drain");
        chk("t1_avail", rb_avail, '0);
        chk("t1_stat", stat_pdu_cnt, 1);

        // Bad header followed by a good PDU.
        write_pdu(0, 6'd0);
        commit(1);
        write_pdu(2, 6'd5);
        commit(3);
        wait_drain("t4_drain");
        chk("t4_err_hdr", err_hdr, 1'b1);
        chk("t4_err_ovf", err_overflow, 1'b0);

        // Partially committed PDU must not start payload reads.
        base_rd = n_pay_rd;
        write_pdu(5, 6'd3);
        commit(3);
        repeat (20) step();
        chk("t5_no_payload_reads", n_pay_rd - base_rd, 0);
        chk("t5_no_output", out_valid, 1'b0);
        commit(3);
        wait_drain("t5_drain");

        // Backpressure: the output buffer fills to exactly its depth and no further.
        out_ready = 1'b0;
        base_rd  = n_pay_rd;
        base_pop = n_pop;
        write_pdu(16, 6'd7);
        commit(17);
        repeat (20) step();
        chk("t3_buffered", (n_pay_rd - base_rd) - (n_pop - base_pop), FIFO_D);
        chk("t3_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        wait_drain("t3_drain");

        // Update and free in the same cycle.
        write_pdu(3, 6'd0);
        commit(4);
        write_pdu(4, 6'd1);
        b = 0;
        while (!rb_free_valid && b < 200) begin
            @(negedge clk);
            b++;
        end
        chk("t6_free_seen", rb_free_valid, 1'b1);
        rb_wr_update_valid = 1'b1;
        rb_wr_update_size  = AW'(5);
        @(posedge clk);
        #1;
        rb_wr_update_valid = 1'b0;
        rb_wr_update_size  = '0;
        uncommitted -= 5;
        chk("t6_avail", rb_avail, 5);
        wait_drain("t6_drain");

        // Random traffic with random backpressure; the small ring wraps many times.
        rand_ready = 1;
        for (int p = 0; p < 150; p++) begin
            if ($urandom_range(0, 9) == 0)
                n = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(33, 40));
            else
                n = int'($urandom_range(1, 32));
            flits = (n == 0 || n > 32) ? 1 : n + 1;
            b = 0;
            while (DEPTH - outstanding < flits && b < 2000) begin
                step();
                b++;
            end
            chk("rand_space", (DEPTH - outstanding) >= flits, 1'b1);
            write_pdu(n, 6'($urandom_range(0, 63)));
            if (flits > 1 && $urandom_range(0, 1) != 0) begin
                k = int'($urandom_range(1, flits - 1));
                commit(k);
                repeat ($urandom_range(0, 3)) step();
                commit(flits - k);
            end else begin
                commit(flits);
            end
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        wait_drain("rand_drain");
        chk("rand_stat", stat_pdu_cnt, n_pdus);
        chk("rand_avail", rb_avail, '0);

        // Reset in the middle of a PDU body.
        out_ready = 1'b0;
        base_rd = n_pay_rd;
        write_pdu(16, 6'd2);
        commit(17);
        repeat (8) step();
        chk("t7_in_body", n_pay_rd > base_rd, 1'b1);
        mon_on = 0;
        rst = 1'b1;
        step();
        check_zero("t7_reset");
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            step();
            if (rb_rd_en) cnt++;
        end
        chk("t7_no_reads", cnt, 0);
        exp_out.delete();
        exp_rd.delete();
        exp_free.delete();
        head = '0;
        outstanding = 0;
        uncommitted = 0;

        // Commit beyond ring depth saturates and flags overflow.
        commit(60);
        commit(10);
        chk("t8_avail_sat", rb_avail, DEPTH);
        chk("t8_err_ovf", err_overflow, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
